// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream producer/consumer pair.
// Frame geometry defaults, sink FSM states and error-flag bit positions.
package pixel_stream_pkg;

  localparam int unsigned DefaultXSize = 640;
  localparam int unsigned DefaultYSize = 480;

  typedef enum logic [0:0] {
    StWaitSof,
    StActive
  } sink_state_e;

  localparam int unsigned ERR_SOF_MISSING    = 0;
  localparam int unsigned ERR_SOF_UNEXPECTED = 1;
  localparam int unsigned ERR_EARLY_EOL      = 2;
  localparam int unsigned ERR_LATE_EOL       = 3;
  localparam int unsigned ERR_BAD_KEEP       = 4;
  localparam int unsigned NumErrFlags        = 5;

endpackage

// File: rtl/stream_xy_counter.sv
// X/Y raster position counter with wrap at end of line and end of frame.
// restart_i forces the current position to (0,0) before any advance.
module stream_xy_counter #(
  parameter int unsigned XSize = 640,
  parameter int unsigned YSize = 480,
  parameter int unsigned XW    = $clog2(XSize),
  parameter int unsigned YW    = $clog2(YSize)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          advance_i,
  input  logic          restart_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          at_eol_o,
  output logic          at_eof_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (advance_i) begin
      if (restart_i) begin
        // Current beat is pixel (0,0); the next one is (1,0).
        x_d = XW'(1);
        y_d = '0;
      end else if (x_q == XW'(XSize - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(YSize - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end else if (restart_i) begin
      x_d = '0;
      y_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign at_eol_o = (x_q == XW'(XSize - 1));
  assign at_eof_o = at_eol_o && (y_q == YW'(YSize - 1));

endmodule

// File: rtl/pixel_stream_sink.sv
// AXI4-Stream video sink: tracks raster position, checks SOF/EOL/tkeep framing,
// and reports a per-frame additive checksum and a completed-frame counter.
module pixel_stream_sink
  import pixel_stream_pkg::*;
#(
  parameter int unsigned X_SIZE = DefaultXSize,
  parameter int unsigned Y_SIZE = DefaultYSize,
  parameter int unsigned FCNT_W = 16
) (
  input  logic                      in_stream_aclk,
  input  logic                      periph_resetn,
  input  logic [31:0]               in_stream_tdata,
  input  logic [3:0]                in_stream_tkeep,
  input  logic                      in_stream_tlast,
  input  logic                      in_stream_tvalid,
  output logic                      in_stream_tready,
  input  logic                      in_stream_tuser,
  input  logic                      stall_en,
  input  logic                      clear_err,
  output logic [$clog2(X_SIZE)-1:0] x_pos,
  output logic [$clog2(Y_SIZE)-1:0] y_pos,
  output logic                      frame_done,
  output logic [FCNT_W-1:0]         frame_count,
  output logic [31:0]               frame_checksum,
  output logic [NumErrFlags-1:0]    err_flags
);

  localparam int unsigned XW = $clog2(X_SIZE);
  localparam int unsigned YW = $clog2(Y_SIZE);

  sink_state_e             state_q, state_d;
  logic                    tready_q;
  logic [31:0]             acc_q, acc_d;
  logic [31:0]             checksum_q, checksum_d;
  logic [FCNT_W-1:0]       count_q, count_d;
  logic                    done_q, done_d;
  logic [NumErrFlags-1:0]  err_q, err_d, err_set;

  logic          accept, sof_beat, pixel, eol, eof, at_eol, at_eof;
  logic [XW-1:0] x_cur;
  logic [YW-1:0] y_cur;

  assign accept   = in_stream_tvalid && tready_q;
  assign sof_beat = accept && in_stream_tuser;
  assign pixel    = accept && ((state_q == StActive) || in_stream_tuser);
  // A SOF beat is always pixel (0,0), whatever the counter currently holds.
  assign eol      = sof_beat ? 1'b0 : at_eol;
  assign eof      = sof_beat ? 1'b0 : at_eof;

  stream_xy_counter #(
    .XSize (X_SIZE),
    .YSize (Y_SIZE),
    .XW    (XW),
    .YW    (YW)
  ) u_xy (
    .clk_i     (in_stream_aclk),
    .rst_ni    (periph_resetn),
    .advance_i (pixel),
    .restart_i (sof_beat),
    .x_o       (x_cur),
    .y_o       (y_cur),
    .at_eol_o  (at_eol),
    .at_eof_o  (at_eof)
  );

  always_comb begin
    err_set = '0;
    err_set[ERR_SOF_MISSING]    = accept && (state_q == StWaitSof) && !in_stream_tuser;
    err_set[ERR_SOF_UNEXPECTED] = sof_beat && (state_q == StActive) &&
                                  ((x_cur != '0) || (y_cur != '0));
    err_set[ERR_EARLY_EOL]      = pixel && in_stream_tlast && !eol;
    err_set[ERR_LATE_EOL]       = pixel && !in_stream_tlast && eol;
    err_set[ERR_BAD_KEEP]       = pixel && (in_stream_tkeep != 4'hF);
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    checksum_d = checksum_q;
    count_d    = count_q;
    done_d     = 1'b0;
    err_d      = (clear_err ? '0 : err_q) | err_set;
    if (pixel) begin
      acc_d   = sof_beat ? in_stream_tdata : acc_q + in_stream_tdata;
      state_d = StActive;
      if (eof) begin
        checksum_d = acc_q + in_stream_tdata;
        count_d    = count_q + FCNT_W'(1);
        done_d     = 1'b1;
        state_d    = StWaitSof;
      end
    end
  end

  always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q    <= StWaitSof;
      tready_q   <= 1'b0;
      acc_q      <= '0;
      checksum_q <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      tready_q   <= ~stall_en;
      acc_q      <= acc_d;
      checksum_q <= checksum_d;
      count_q    <= count_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_stream_tready = tready_q;
  assign x_pos            = x_cur;
  assign y_pos            = y_cur;
  assign frame_done       = done_q;
  assign frame_count      = count_q;
  assign frame_checksum   = checksum_q;
  assign err_flags        = err_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Directed bench for pixel_stream_sink on a 4x3 raster (12 beats, data 1..12 sums to 78).
module tb_pixel_stream_sink;

  localparam int unsigned XS = 4;
  localparam int unsigned YS = 3;
  localparam int unsigned FW = 16;
  localparam logic [11:0] MaskOk    = 12'b1000_1000_1000;
  localparam logic [11:0] MaskEarly = 12'b1000_1000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tvalid, tready, tuser, stall_en, clear_err;
  logic [1:0]  x_pos, y_pos;
  logic        frame_done;
  logic [FW-1:0] frame_count;
  logic [31:0] frame_checksum;
  logic [4:0]  err_flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit stall_mode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_stream_sink #(
    .X_SIZE (XS),
    .Y_SIZE (YS),
    .FCNT_W (FW)
  ) dut (
    .in_stream_aclk   (clk),
    .periph_resetn    (rst_n),
    .in_stream_tdata  (tdata),
    .in_stream_tkeep  (tkeep),
    .in_stream_tlast  (tlast),
    .in_stream_tvalid (tvalid),
    .in_stream_tready (tready),
    .in_stream_tuser  (tuser),
    .stall_en         (stall_en),
    .clear_err        (clear_err),
    .x_pos            (x_pos),
    .y_pos            (y_pos),
    .frame_done       (frame_done),
    .frame_count      (frame_count),
    .frame_checksum   (frame_checksum),
    .err_flags        (err_flags)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Holds the beat on the bus until the sink accepts it; optionally checks position each cycle.
  task automatic send_beat(input logic [31:0] data, input logic user, input logic last,
                           input logic [3:0] keep, input logic clr, input bit pchk,
                           input int ex, input int ey);
    bit   done = 0;
    int   budget = 0;
    logic rdy;
    while (!done) begin
      @(negedge clk);
      if (stall_mode) stall_en = ((cyc % 6) >= 3);
      tvalid = 1'b1; tdata = data; tuser = user; tlast = last; tkeep = keep; clear_err = clr;
      if (pchk) begin
        check_eq("x_pos", 32'(x_pos), 32'(ex));
        check_eq("y_pos", 32'(y_pos), 32'(ey));
      end
      rdy = tready;
      @(posedge clk);
      if (rdy) done = 1;
      else begin
        budget++;
        if (budget > 40) begin
          check_eq("accept_timeout", budget, 40);
          done = 1;
        end
      end
    end
  endtask

  task automatic send_frame(input logic [11:0] last_mask, input int keep_beat,
                            input int clr_beat, input bit pchk);
    for (int k = 1; k <= 12; k++) begin
      send_beat(32'(k), k == 1, last_mask[k-1], (k == keep_beat) ? 4'h7 : 4'hF,
                k == clr_beat, pchk, (k - 1) % XS, (k - 1) / XS);
    end
  endtask

  task automatic end_frame(input logic exp_done, input int exp_cnt, input logic [31:0] exp_sum,
                           input logic [4:0] exp_err);
    @(negedge clk);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; clear_err = 1'b0;
    check_eq("frame_done_pulse", 32'(frame_done), 32'(exp_done));
    check_eq("frame_count", 32'(frame_count), 32'(exp_cnt));
    check_eq("frame_checksum", frame_checksum, exp_sum);
    check_eq("err_flags", 32'(err_flags), 32'(exp_err));
    @(negedge clk);
    check_eq("frame_done_low", 32'(frame_done), 32'd0);
    check_eq("x_after_frame", 32'(x_pos), 32'd0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check_eq("err_cleared", 32'(err_flags), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; tdata = '0; tkeep = 4'hF; tlast = 0; tvalid = 0; tuser = 0;
    stall_en = 0; clear_err = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_tready", 32'(tready), 32'd0);
    check_eq("rst_pos", 32'({x_pos, y_pos}), 32'd0);
    check_eq("rst_count", 32'(frame_count), 32'd0);
    check_eq("rst_sum", frame_checksum, 32'd0);
    check_eq("rst_err", 32'(err_flags), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("tready_first_edge", 32'(tready), 32'd1);

    // Clean frame
    send_frame(MaskOk, 0, 0, 1);
    end_frame(1'b1, 1, 32'd78, 5'b00000);

    // Same frame under periodic backpressure
    stall_mode = 1;
    send_frame(MaskOk, 0, 0, 1);
    end_frame(1'b1, 2, 32'd78, 5'b00000);
    stall_mode = 0;
    stall_en = 1'b0;

    // Beats before SOF are discarded and flagged
    for (int i = 0; i < 3; i++) send_beat(32'(100 + i), 1'b0, 1'b0, 4'hF, 1'b0, 1, 0, 0);
    send_frame(MaskOk, 0, 0, 1);
    end_frame(1'b1, 3, 32'd78, 5'b00001);
    do_clear();

    // tlast one beat early: early on beat 3, late on beat 4
    send_frame(MaskEarly, 0, 0, 1);
    end_frame(1'b1, 4, 32'd78, 5'b01100);
    do_clear();

    // SOF in the middle of a frame restarts it
    for (int k = 1; k <= 6; k++)
      send_beat(32'(200 + k), k == 1, k == 4, 4'hF, 1'b0, 1, (k - 1) % XS, (k - 1) / XS);
    send_frame(MaskOk, 0, 0, 0);
    end_frame(1'b1, 5, 32'd78, 5'b00010);
    do_clear();

    // Bad tkeep still summed
    send_frame(MaskOk, 5, 0, 1);
    end_frame(1'b1, 6, 32'd78, 5'b10000);
    do_clear();

    // clear_err on the same edge as a new bad_keep: old flag cleared, new flag kept
    send_beat(32'd9, 1'b0, 1'b0, 4'hF, 1'b0, 1, 0, 0);
    send_frame(MaskOk, 5, 5, 1);
    end_frame(1'b1, 7, 32'd78, 5'b10000);

    // Asynchronous reset mid-frame
    for (int k = 1; k <= 5; k++)
      send_beat(32'(k), k == 1, k == 4, 4'h7, 1'b0, 0, 0, 0);
    @(negedge clk);
    tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_pos", 32'({x_pos, y_pos}), 32'd0);
    check_eq("midrst_count", 32'(frame_count), 32'd0);
    check_eq("midrst_err", 32'(err_flags), 32'd0);
    check_eq("midrst_tready", 32'(tready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(MaskOk, 0, 0, 1);
    end_frame(1'b1, 1, 32'd78, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_stream_sink.md
Name: pixel_stream_sink

Overview:
- AXI4-Stream video receiver: the consuming end of the pixel stream that pixel_generator produces (32-bit tdata, tkeep, tlast = end-of-line, tuser = start-of-frame).
- Accepts beats and tracks the expected x/y position of each pixel.
- Checks framing (SOF, EOL, tkeep).
- Per frame, accumulates an additive checksum and counts the frame when it completes.
- Used as the downstream endpoint in standalone generator benches and as an on-chip frame monitor ahead of VDMA.

Parameters:
- X_SIZE, 640, pixels per line (≥2).
- Y_SIZE, 480, lines per frame (≥2).
- FCNT_W, 16, width of frame_count.

Ports:
- in_stream_aclk  in  1  sole clock, rising edge.
- periph_resetn  in  1  asynchronous, active-low reset.
- in_stream_tdata  in  32  pixel data.
- in_stream_tkeep  in  4  byte enables; must be 4'hF.
- in_stream_tlast  in  1  end of line.
- in_stream_tvalid  in  1  beat valid.
- in_stream_tready  out  1  sink ready.
- in_stream_tuser  in  1  start of frame.
- stall_en  in  1  when 1, sink deasserts tready (backpressure injection).
- clear_err  in  1  one-cycle pulse; clears sticky error flags.
- x_pos  out  $clog2(X_SIZE)  expected column of next beat.
- y_pos  out  $clog2(Y_SIZE)  expected row of next beat.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_count  out  FCNT_W  completed frames, wraps at 2^FCNT_W.
- frame_checksum  out  32  sum of tdata mod 2^32 over last completed frame.
- err_flags  out  5  sticky flags:
  - [0] sof_missing
  - [1] sof_unexpected
  - [2] early_eol
  - [3] late_eol
  - [4] bad_keep

Behaviour:
- Reset values: all outputs 0 (tready 0, x_pos/y_pos 0, frame_count 0, checksum 0, err_flags 0, frame_done 0). State = WAIT_SOF.
- tready is a register loaded with ~stall_en each cycle: one-cycle latency from stall_en. First possible 1 is the first edge after reset release.
- Accept = tvalid && tready at the rising edge. Nothing changes on non-accepted cycles. Source may hold tvalid indefinitely.
- FSM states:
  - WAIT_SOF:
    - Accepted beat with tuser=1 → treated as pixel (0,0). Processed as in ACTIVE, state → ACTIVE.
    - Accepted beat with tuser=0 → discarded, set sof_missing, position unchanged.
  - ACTIVE, for each accepted beat:
    - tuser=1 while (x_pos,y_pos)≠(0,0): set sof_unexpected. Discard partial frame (accumulator reset, no frame counted). Treat the beat as pixel (0,0) of a new frame.
    - tlast=1 with x_pos≠X_SIZE-1: set early_eol.
    - tlast=0 with x_pos=X_SIZE-1: set late_eol.
    - tkeep≠4'hF: set bad_keep. Pixel still counted and summed.
    - Position advances by count, not by tlast. x wraps X_SIZE-1→0 and increments y.
    - Accumulator += tdata (mod 2^32); the first beat of a frame loads acc = tdata.
    - Beat at (X_SIZE-1, Y_SIZE-1):
      - On the same edge: frame_checksum ← acc+tdata, frame_count ← frame_count+1.
      - On the following cycle: frame_done = 1 for exactly one cycle.
      - x_pos,y_pos → 0 and state → WAIT_SOF.
- Errors are detected even on the final beat.
- clear_err zeroes err_flags. If clear_err coincides with a new error event, the new bit ends up set (set wins).
- Asynchronous reset mid-frame: immediate return to reset values; the partial frame is lost.
- frame_count wraps to 0 silently.

Decomposition:
- Package pixel_stream_pkg:
  - default X_SIZE/Y_SIZE localparams shared with pixel_generator.
  - state enum {WAIT_SOF, ACTIVE}.
  - err_flags bit-index constants (ERR_SOF_MISSING..ERR_BAD_KEEP).
- Sub-module stream_xy_counter:
  - parameterised X/Y wrap counter.
  - inputs: advance, restart.
  - outputs: x, y, at_eol, at_eof.

Test Plan (X_SIZE=4, Y_SIZE=3, 12 beats/frame):
- Reset, stall_en=0 → tready=1 on 1st edge after release. Send one clean frame, tdata=1..12, tuser on beat 1, tlast on beats 4/8/12 → frame_done pulse one cycle after beat 12, frame_count=1, frame_checksum=78, err_flags=0.
- Same frame with stall_en toggled every 3 cycles and tvalid held → identical result; no beat lost or duplicated; x_pos/y_pos frozen while tready=0.
- Three beats with tuser=0 before the SOF, then a clean frame → err_flags=5'b00001, frame_count=1, checksum 78. Then clear_err → err_flags=0.
- tlast on beat 3 instead of 4; frame otherwise clean → early_eol and late_eol (beat 4) set, frame still counted.
- New tuser=1 at beat 7, then 12 clean beats tdata=1..12 → sof_unexpected set, frame_count=1, checksum 78.
- tkeep=4'h7 on beat 5 → bad_keep set, checksum 78. clear_err asserted on the same edge as a new bad_keep beat → bad_keep remains 1.
